alu_sequencer: RTL and testbench

- Control-side initiator for the 4-bit accumulator/ALU unit (the `uni` datapath).
- Fetches 8-bit instructions from an asynchronous program ROM and drives the unit's control inputs EN, EB1, EB2, in and S.
- Captures the unit's C/Z flags and uses them to resolve conditional jumps, turning the hand-stepped datapath into a small programmable nibble processor.

---
 rtl/alu_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 4-bit accumulator/ALU unit: fetches 1- or 2-byte
// instructions, drives EN/EB1/EB2/in/S and resolves conditional jumps on C/Z flags.
module alu_sequencer #(
  parameter int unsigned        ADDR_W   = 12,
  parameter logic [ADDR_W-1:0]  RESET_PC = 12'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic              C,
  input  logic              Z,
  output logic              EN,
  output logic              EB1,
  output logic              EB2,
  output logic [3:0]        in,
  output logic [2:0]        S,
  output logic              c_flag,
  output logic              z_flag,
  output logic              halted
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_FETCH2 = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_HALT = 4'h1;
  localparam logic [3:0] OP_OUT  = 4'h2;
  localparam logic [3:0] OP_JC   = 4'h3;
  localparam logic [3:0] OP_JNC  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_JNZ  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;

  typedef struct packed {
    logic       en;
    logic       eb1;
    logic       eb2;
    logic [3:0] operand;
    logic [2:0] sel;
  } ctrl_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        ir;
  logic [7:0]        lo;
  logic              jump_taken;
  logic              fetch_two_byte;
  ctrl_t             ctrl;

  wire [3:0] opcode  = ir[7:4];
  wire [3:0] operand = ir[3:0];
  wire       is_alu  = opcode[3];

  // Opcodes 0x3-0x7 carry a second byte (low 8 bits of the jump target).
  assign fetch_two_byte = (prog_data[7:4] >= OP_JC) && (prog_data[7:4] <= OP_JMP);

  always_comb begin
    jump_taken = 1'b0;
    case (opcode)
      OP_JMP:  jump_taken = 1'b1;
      OP_JC:   jump_taken = c_flag;
      OP_JNC:  jump_taken = ~c_flag;
      OP_JZ:   jump_taken = z_flag;
      OP_JNZ:  jump_taken = ~z_flag;
      default: jump_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      lo     <= '0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else if (!hold) begin
      case (state)
        ST_FETCH: begin
          ir    <= prog_data;
          pc    <= pc + ADDR_W'(1);
          state <= fetch_two_byte ? ST_FETCH2 : ST_EXEC;
        end
        ST_FETCH2: begin
          lo    <= prog_data;
          pc    <= pc + ADDR_W'(1);
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (is_alu) begin
            c_flag <= C;
            z_flag <= Z;
          end
          // Not-taken jumps leave PC alone: it already points past the second byte.
          if (jump_taken)
            pc <= ADDR_W'({operand, lo});
          state <= (opcode == OP_HALT) ? ST_HALT : ST_FETCH;
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  // Controls are only live in EXECUTE so each ALU op yields exactly one EN pulse.
  always_comb begin
    ctrl = '0;
    if (!hold && state == ST_EXEC) begin
      if (is_alu) begin
        ctrl.en      = 1'b1;
        ctrl.eb1     = 1'b1;
        ctrl.eb2     = 1'b1;
        ctrl.operand = operand;
        ctrl.sel     = opcode[2:0];
      end else if (opcode == OP_OUT) begin
        ctrl.eb2 = 1'b1;
      end
    end
  end

  assign EN        = ctrl.en;
  assign EB1       = ctrl.eb1;
  assign EB2       = ctrl.eb2;
  assign in        = ctrl.operand;
  assign S         = ctrl.sel;
  assign prog_addr = pc;
  assign halted    = (state == ST_HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: instruction-level reference interpreter predicts
// every cycle's outputs for directed programs and a random ROM with random holds.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hold = 1'b0;
  logic [11:0] prog_addr;
  logic [7:0]  prog_data;
  logic        C = 1'b0, Z = 1'b0;
  logic        EN, EB1, EB2;
  logic [3:0]  in;
  logic [2:0]  S;
  logic        c_flag, z_flag, halted;

  logic [7:0]  rom [0:4095];

  int          total = 0;
  int          passed = 0;

  // reference model state
  logic [11:0] m_pc;
  logic        m_c, m_z, m_halted;
  bit          cz_fixed = 1'b0;
  logic        c_val = 1'b0, z_val = 1'b0;

  always #5 clk = ~clk;

  assign prog_data = rom[prog_addr];

  alu_sequencer #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .C(C), .Z(Z),
    .EN(EN), .EB1(EB1), .EB2(EB2), .in(in), .S(S),
    .c_flag(c_flag), .z_flag(z_flag), .halted(halted)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic int rnd_hold();
    return ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  // One architectural cycle, preceded by nhold frozen cycles.
  // Returns the C/Z presented on the cycle that actually executes.
  task automatic cyc(input string tag, input logic [11:0] ea, input logic [2:0] ectl,
                     input logic [3:0] ein, input logic [2:0] es, input logic eh,
                     input int nhold, output logic sc, output logic sz);
    for (int i = 0; i <= nhold; i++) begin
      @(negedge clk);
      hold = (i < nhold);
      C = cz_fixed ? c_val : 1'($urandom);
      Z = cz_fixed ? z_val : 1'($urandom);
      #1;
      if (hold)
        chk({tag, "_hold_ctrl"}, 16'({EN, EB1, EB2, in, S}), 16'h0);
      else
        chk({tag, "_ctrl"}, 16'({EN, EB1, EB2, in, S}), 16'({ectl, ein, es}));
      chk({tag, "_addr"}, 16'(prog_addr), 16'(ea));
      chk({tag, "_halted"}, 16'(halted), 16'(eh));
      chk({tag, "_flags"}, 16'({c_flag, z_flag}), 16'({m_c, m_z}));
      sc = C;
      sz = Z;
    end
  endtask

  task automatic run_instr(input int xh, input bit rnd);
    logic [7:0] ir, lo;
    logic [3:0] op;
    logic       sc, sz, tk;
    lo = 8'h00;
    ir = rom[m_pc];
    op = ir[7:4];
    cyc("fetch", m_pc, 3'b000, 4'h0, 3'h0, 1'b0, rnd ? rnd_hold() : 0, sc, sz);
    m_pc = m_pc + 12'd1;
    if (op >= 4'h3 && op <= 4'h7) begin
      lo = rom[m_pc];
      cyc("fetch2", m_pc, 3'b000, 4'h0, 3'h0, 1'b0, rnd ? rnd_hold() : 0, sc, sz);
      m_pc = m_pc + 12'd1;
    end
    if (op >= 4'h8) begin
      cyc("exec_alu", m_pc, 3'b111, ir[3:0], op[2:0], 1'b0, xh, sc, sz);
      m_c = sc;
      m_z = sz;
    end else if (op == 4'h2) begin
      cyc("exec_out", m_pc, 3'b001, 4'h0, 3'h0, 1'b0, xh, sc, sz);
    end else begin
      cyc("exec_misc", m_pc, 3'b000, 4'h0, 3'h0, 1'b0, xh, sc, sz);
      tk = (op == 4'h7) || (op == 4'h3 && m_c) || (op == 4'h4 && !m_c) ||
           (op == 4'h5 && m_z) || (op == 4'h6 && !m_z);
      if (tk) m_pc = {ir[3:0], lo};
      if (op == 4'h1) m_halted = 1'b1;
    end
  endtask

  task automatic halt_cycles(input int n, input bit rnd);
    logic sc, sz;
    for (int i = 0; i < n; i++)
      cyc("halt", m_pc, 3'b000, 4'h0, 3'h0, 1'b1, rnd ? rnd_hold() : 0, sc, sz);
  endtask

  // Assert reset in the low phase, check the cleared outputs, release mid-high phase.
  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b0;
    hold = 1'($urandom);
    #1;
    chk("rst_ctrl", 16'({EN, EB1, EB2, in, S}), 16'h0);
    chk("rst_addr", 16'(prog_addr), 16'h000);
    chk("rst_halted", 16'(halted), 16'h0);
    chk("rst_flags", 16'({c_flag, z_flag}), 16'h0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    hold     = 1'b0;
    m_pc     = 12'h000;
    m_c      = 1'b0;
    m_z      = 1'b0;
    m_halted = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  initial begin
    logic sc, sz;
    clear_rom();
    m_pc = 12'h000; m_c = 1'b0; m_z = 1'b0; m_halted = 1'b0;

    // power-on reset
    do_reset();

    // reset arriving in FETCH2 of a JMP aborts it; restart reads address 0
    rom[0] = 8'h71; rom[1] = 8'h23;
    cyc("jmp_fetch", m_pc, 3'b000, 4'h0, 3'h0, 1'b0, 0, sc, sz);
    do_reset();

    // unconditional jump to 0x123, then fetch from there
    run_instr(0, 1'b0);
    chk("jmp_model_target", 16'(m_pc), 16'h123);
    run_instr(0, 1'b0);

    // ALU/ALU/OUT sequence with C=1,Z=0 on the second ALU op
    do_reset();
    rom[0] = 8'h8A; rom[1] = 8'h93; rom[2] = 8'h20;
    cz_fixed = 1'b1; c_val = 1'b0; z_val = 1'b1;
    run_instr(0, 1'b0);
    c_val = 1'b1; z_val = 1'b0;
    run_instr(0, 1'b0);
    run_instr(0, 1'b0);
    cyc("after_out", 12'h003, 3'b000, 4'h0, 3'h0, 1'b0, 0, sc, sz);

    // same program, 5 hold cycles on the second ALU EXECUTE
    do_reset();
    c_val = 1'b0; z_val = 1'b1;
    run_instr(0, 1'b0);
    c_val = 1'b1; z_val = 1'b0;
    run_instr(5, 1'b0);
    run_instr(0, 1'b0);

    // conditional jumps and PC wrap
    do_reset();
    clear_rom();
    rom[12'h000] = 8'h80;                          // ALU with C=1,Z=1
    rom[12'h001] = 8'h50; rom[12'h002] = 8'h45;    // JZ 0x045 taken
    rom[12'h045] = 8'h60; rom[12'h046] = 8'h45;    // JNZ not taken
    rom[12'h047] = 8'h30; rom[12'h048] = 8'h99;    // JC 0x099 taken
    rom[12'h099] = 8'h40; rom[12'h09A] = 8'h99;    // JNC not taken
    rom[12'h09B] = 8'h8F;                          // ALU with C=0,Z=0
    rom[12'h09C] = 8'h61; rom[12'h09D] = 8'h00;    // JNZ 0x100 taken
    rom[12'h100] = 8'h4F; rom[12'h101] = 8'hFF;    // JNC 0xFFF taken
    rom[12'hFFF] = 8'h00;                          // NOP, PC wraps
    c_val = 1'b1; z_val = 1'b1;
    run_instr(0, 1'b0);
    c_val = 1'b0; z_val = 1'b0;
    for (int i = 0; i < 4; i++) run_instr(0, 1'b0);
    run_instr(0, 1'b0);
    for (int i = 0; i < 3; i++) run_instr(0, 1'b0);
    chk("wrap_model_pc", 16'(m_pc), 16'h000);
    run_instr(0, 1'b0);

    // HALT holds everything for 20 cycles until reset
    do_reset();
    rom[0] = 8'h85; rom[1] = 8'h10;
    run_instr(0, 1'b0);
    run_instr(0, 1'b0);
    halt_cycles(20, 1'b0);
    do_reset();

    // random program with random hold bursts
    cz_fixed = 1'b0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    for (int n = 0; n < 400; n++) begin
      run_instr(($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b1);
      if (m_halted) begin
        halt_cycles(3, 1'b1);
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
